// File: rtl/top.sv
// Front-panel PDP-8 subset: 4K x 12 memory, four-state instruction FSM,
// debounced-by-edge panel buttons and a 4-digit octal PC/AC display.
module top #(
  parameter int REFRESH_BITS = 17
) (
  input  logic        clk,
  input  logic        btnCpuReset,
  input  logic        btnc,
  input  logic        btnu,
  input  logic        btnd,
  input  logic        btnl,
  input  logic        btnr,
  input  logic [12:0] sw,
  output logic [15:0] led,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int BC = 0, BU = 1, BD = 2, BL = 3, BR = 4;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DEFER, S_EXEC} state_e;

  state_e      state_q, state_d;
  logic [11:0] pc_q, pc_d, ac_q, ac_d, ir_q, ir_d, ma_q, ma_d;
  logic        l_q, l_d, halt_q, halt_d;
  logic        dsel_q, sw12_q;
  logic [REFRESH_BITS-1:0] cnt_q;

  logic [4:0]  btn_raw, s1_q, s2_q, s3_q, pulse;
  logic        running;

  logic [11:0] mem [4096];
  logic [11:0] mem_pc, mem_ma, ma_inc;
  logic        mem_we;
  logic [11:0] mem_wa, mem_wd;
  logic [12:0] lac;
  logic        skip;

  assign btn_raw = {btnr, btnl, btnd, btnu, btnc};
  // s3 holds the previous synchronized level, so a held button yields one pulse
  assign pulse   = s2_q & ~s3_q;
  assign running = sw[12] & ~halt_q;
  assign mem_pc  = mem[pc_q];
  assign mem_ma  = mem[ma_q];
  assign ma_inc  = mem_ma + 12'd1;

  // Button synchronizers and edge-detect history
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // Main memory: single write port, not cleared by reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  // CPU state, display select, RUN-switch history and refresh counter
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ac_q    <= '0;
      ir_q    <= '0;
      ma_q    <= '0;
      l_q     <= 1'b0;
      halt_q  <= 1'b0;
      dsel_q  <= 1'b0;
      sw12_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      ir_q    <= ir_d;
      ma_q    <= ma_d;
      l_q     <= l_d;
      halt_q  <= halt_d;
      dsel_q  <= dsel_q ^ pulse[BC];
      sw12_q  <= sw[12];
      cnt_q   <= cnt_q + REFRESH_BITS'(1);
    end
  end

  // Next-state: panel actions in IDLE, instruction cycle otherwise
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    ir_d    = ir_q;
    ma_d    = ma_q;
    l_d     = l_q;
    halt_d  = halt_q;
    mem_we  = 1'b0;
    mem_wa  = pc_q;
    mem_wd  = sw[11:0];
    lac     = {l_q, ac_q};
    skip    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (running) begin
          state_d = S_FETCH;
        end else if (pulse[BL]) begin
          pc_d   = sw[11:0];
          halt_d = 1'b0;
        end else if (pulse[BD]) begin
          mem_we = 1'b1;
          pc_d   = pc_q + 12'd1;
        end else if (pulse[BR]) begin
          ac_d = sw[11:0];
        end else if (pulse[BU]) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = mem_pc;
        pc_d    = pc_q + 12'd1;
        ma_d    = {mem_pc[7] ? pc_q[11:7] : 5'b0, mem_pc[6:0]};
        state_d = (mem_pc[8] && mem_pc[11:9] < 3'd6) ? S_DEFER : S_EXEC;
      end
      S_DEFER: begin
        // Locations 0010-0017 auto-increment their pointer before use
        if (ma_q[11:3] == 9'o001) begin
          mem_we = 1'b1;
          mem_wa = ma_q;
          mem_wd = ma_inc;
          ma_d   = ma_inc;
        end else begin
          ma_d = mem_ma;
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_IDLE;
        mem_wa  = ma_q;
        unique case (ir_q[11:9])
          3'd0: ac_d = ac_q & mem_ma;
          3'd1: begin
            lac  = {l_q, ac_q} + {1'b0, mem_ma};
            l_d  = lac[12];
            ac_d = lac[11:0];
          end
          3'd2: begin
            mem_we = 1'b1;
            mem_wd = ma_inc;
            if (ma_inc == 12'd0) pc_d = pc_q + 12'd1;
          end
          3'd3: begin
            mem_we = 1'b1;
            mem_wd = ac_q;
            ac_d   = '0;
          end
          3'd4: begin
            mem_we = 1'b1;
            mem_wd = pc_q;
            pc_d   = ma_q + 12'd1;
          end
          3'd5: pc_d = ma_q;
          3'd6: ;
          3'd7: begin
            if (!ir_q[8]) begin
              if (ir_q[7]) lac[11:0] = '0;
              if (ir_q[6]) lac[12]   = 1'b0;
              if (ir_q[5]) lac[11:0] = ~lac[11:0];
              if (ir_q[4]) lac[12]   = ~lac[12];
              if (ir_q[0]) lac       = lac + 13'd1;
              if (ir_q[3]) begin
                lac = {lac[0], lac[12:1]};
                if (ir_q[1]) lac = {lac[0], lac[12:1]};
              end else if (ir_q[2]) begin
                lac = {lac[11:0], lac[12]};
                if (ir_q[1]) lac = {lac[11:0], lac[12]};
              end
              l_d  = lac[12];
              ac_d = lac[11:0];
            end else if (!ir_q[0]) begin
              // Skip test sees AC/L as they were before CLA/OSR
              skip = (ir_q[6] & ac_q[11]) | (ir_q[5] & (ac_q == 12'd0)) | (ir_q[4] & l_q);
              if (ir_q[3]) skip = ~skip;
              if (skip) pc_d = pc_q + 12'd1;
              if (ir_q[7]) ac_d = '0;
              if (ir_q[2]) ac_d = ac_d | sw[11:0];
              if (ir_q[1]) halt_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    // Turning RUN off releases a halted machine
    if (sw12_q && !sw[12]) halt_d = 1'b0;
  end

  logic [1:0]  dig;
  logic [11:0] shown;
  logic [2:0]  oct;
  logic [6:0]  seg_pat;

  assign dig   = cnt_q[REFRESH_BITS-1 -: 2];
  assign shown = dsel_q ? ac_q : pc_q;

  // Octal digit select and active-low segment decode (bit0 = a .. bit6 = g)
  always_comb begin
    unique case (dig)
      2'd0: oct = shown[2:0];
      2'd1: oct = shown[5:3];
      2'd2: oct = shown[8:6];
      default: oct = shown[11:9];
    endcase
    unique case (oct)
      3'd0: seg_pat = 7'h40;
      3'd1: seg_pat = 7'h79;
      3'd2: seg_pat = 7'h24;
      3'd3: seg_pat = 7'h30;
      3'd4: seg_pat = 7'h19;
      3'd5: seg_pat = 7'h12;
      3'd6: seg_pat = 7'h02;
      default: seg_pat = 7'h78;
    endcase
  end

  // Outputs are blanked while reset is held (RUN switch may still be up)
  assign led = btnCpuReset ? {1'b0, halt_q, running, l_q, ac_q} : 16'h0000;
  assign an  = btnCpuReset ? {4'hF, ~(4'b0001 << dig)} : 8'hFF;
  assign seg = btnCpuReset ? seg_pat : 7'h7F;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed panel/CPU scenarios, display scan,
// and random single-stepped instructions against an instruction-level model.
module tb_top;
  localparam int RB = 4;
  localparam int BC = 0, BU = 1, BD = 2, BL = 3, BR = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  btns = '0;
  logic [12:0] sw = '0;
  logic [15:0] led;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_tests = 0, n_fail = 0;
  int m [4096];
  int mpc, mac, ml, mhalt, mea, mptr;
  logic [6:0] pat [8];

  top #(.REFRESH_BITS(RB)) dut (
    .clk(clk), .btnCpuReset(rst_n),
    .btnc(btns[BC]), .btnu(btns[BU]), .btnd(btns[BD]), .btnl(btns[BL]), .btnr(btns[BR]),
    .sw(sw), .led(led), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o", tag, got, exp);
    end
  endtask

  task automatic press(input logic [4:0] mask);
    @(negedge clk);
    btns = mask;
    repeat (4) @(negedge clk);
    btns = '0;
    repeat (8) @(negedge clk);
  endtask

  task automatic load_pc(input int a);
    sw[11:0] = 12'(a);
    press(5'(1 << BL));
    mpc = a; mhalt = 0;
  endtask

  task automatic deposit(input int a, input int v);
    load_pc(a);
    sw[11:0] = 12'(v);
    press(5'(1 << BD));
    m[a] = v; mpc = (a + 1) % 4096;
  endtask

  task automatic load_ac(input int v);
    sw[11:0] = 12'(v);
    press(5'(1 << BR));
    mac = v;
  endtask

  // One instruction, from the architectural rules
  task automatic model_step();
    int p, ir, op, ea, v, skip;
    p = mpc; ir = m[p]; mpc = (mpc + 1) % 4096; op = ir / 512;
    ea = ((ir & 128) != 0 ? (p & 'o7600) : 0) + (ir & 127);
    mptr = -1;
    if (op < 6 && (ir & 256) != 0) begin
      if (ea >= 8 && ea <= 15) begin
        m[ea] = (m[ea] + 1) % 4096;
        mptr = ea;
      end
      ea = m[ea];
    end
    mea = ea;
    case (op)
      0: mac = mac & m[ea];
      1: begin v = ml * 4096 + mac + m[ea]; ml = (v / 4096) % 2; mac = v % 4096; end
      2: begin m[ea] = (m[ea] + 1) % 4096; if (m[ea] == 0) mpc = (mpc + 1) % 4096; end
      3: begin m[ea] = mac; mac = 0; end
      4: begin m[ea] = mpc; mpc = (ea + 1) % 4096; end
      5: mpc = ea;
      6: ;
      default: begin
        if ((ir & 256) == 0) begin
          if ((ir & 128) != 0) mac = 0;
          if ((ir & 64) != 0) ml = 0;
          if ((ir & 32) != 0) mac = 4095 - mac;
          if ((ir & 16) != 0) ml = 1 - ml;
          v = ml * 4096 + mac;
          if ((ir & 1) != 0) v = (v + 1) % 8192;
          for (int k = 0; k < (((ir & 2) != 0) ? 2 : 1); k++) begin
            if ((ir & 8) != 0) v = (v >> 1) + (v & 1) * 4096;
            else if ((ir & 4) != 0) v = ((v << 1) % 8192) + (v >> 12);
          end
          ml = v / 4096; mac = v % 4096;
        end else if ((ir & 1) == 0) begin
          skip = (((ir & 64) != 0) && mac >= 2048) || (((ir & 32) != 0) && mac == 0) ||
                 (((ir & 16) != 0) && ml == 1);
          if ((ir & 8) != 0) skip = !skip;
          if (skip) mpc = (mpc + 1) % 4096;
          if ((ir & 128) != 0) mac = 0;
          if ((ir & 4) != 0) mac = mac | int'(sw[11:0]);
          if ((ir & 2) != 0) mhalt = 1;
        end
      end
    endcase
  endtask

  task automatic step_at(input int p);
    load_pc(p);
    press(5'(1 << BU));
    model_step();
  endtask

  task automatic check_cpu(input string tag);
    chk({tag, "_pc"}, int'(dut.pc_q), mpc);
    chk({tag, "_ac"}, int'(led[11:0]), mac);
    chk({tag, "_l"}, int'(led[12]), ml);
    chk({tag, "_halt"}, int'(led[14]), mhalt);
  endtask

  // Scan one full refresh period and check every lit digit
  task automatic disp_check(input string tag, input int val);
    int seen, nz, idx;
    seen = 0;
    repeat (1 << RB) begin
      @(negedge clk);
      nz = 0; idx = 0;
      for (int i = 0; i < 4; i++) if (an[i] == 1'b0) begin nz++; idx = i; end
      chk({tag, "_onehot"}, nz, 1);
      chk({tag, "_an_hi"}, int'(an[7:4]), 15);
      chk({tag, "_seg"}, int'(seg), int'(pat[(val >> (3 * idx)) & 7]));
      seen = seen | (1 << idx);
    end
    chk({tag, "_digits"}, seen, 15);
  endtask

  initial begin
    int p, op, ir, ind, pg, offs, ea, ptr, tgt, val, r;
    bit ok;
    pat = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
    for (int i = 0; i < 4096; i++) m[i] = 0;

    // Reset: outputs blanked even with every switch up
    sw = 13'h1FFF; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_led", int'(led), 0);
    chk("rst_an", int'(an), 'hFF);
    chk("rst_seg", int'(seg), 'h7F);
    chk("rst_dp", int'(dp), 1);
    chk("rst_pc", int'(dut.pc_q), 0);
    sw = '0;
    @(negedge clk);
    rst_n = 1'b1;
    mpc = 0; mac = 0; ml = 0; mhalt = 0;
    @(negedge clk);
    check_cpu("post_rst");

    // Load PC then deposit, long presses act once
    deposit('o200, 'o7001);
    chk("dep_mem", int'(dut.mem['o200]), 'o7001);
    chk("dep_pc", int'(dut.pc_q), 'o201);

    // Small program run with RUN switch until HLT
    deposit('o200, 'o7200); deposit('o201, 'o1203);
    deposit('o202, 'o7402); deposit('o203, 'o0005);
    load_pc('o200);
    sw[12] = 1'b1;
    repeat (40) @(negedge clk);
    for (int k = 0; k < 10 && mhalt == 0; k++) model_step();
    chk("run_ac", int'(led[11:0]), 'o0005);
    chk("run_halt", int'(led[14]), 1);
    chk("run_pc", int'(dut.pc_q), 'o203);
    chk("run_running", int'(led[13]), 0);
    check_cpu("run");
    sw[12] = 1'b0;
    repeat (3) @(negedge clk);
    mhalt = 0;
    chk("run_fall_halt", int'(led[14]), 0);

    // TAD carry out of 7777
    load_ac('o7777);
    chk("tad_l_pre", int'(led[12]), 0);
    deposit('o300, 'o0001);
    deposit('o250, 'o1300);
    step_at('o250);
    chk("tad_ac", int'(led[11:0]), 0);
    chk("tad_l", int'(led[12]), 1);
    check_cpu("tad");

    // ISZ wraps to zero and skips the JMP
    deposit('o310, 'o7777);
    deposit('o260, 'o2310);
    deposit('o261, 'o5300);
    step_at('o260);
    chk("isz_mem", int'(dut.mem['o310]), 0);
    chk("isz_pc", int'(dut.pc_q), 'o262);

    // JMS stores return address
    deposit('o200, 'o4300);
    step_at('o200);
    chk("jms_mem", int'(dut.mem['o300]), 'o201);
    chk("jms_pc", int'(dut.pc_q), 'o301);
    check_cpu("jms");

    // Coinciding presses: Load-PC beats Deposit, Deposit beats Load-AC
    deposit('o1234, 'o1111);
    sw[11:0] = 12'o1234;
    press(5'((1 << BL) | (1 << BD)));
    mpc = 'o1234;
    chk("prio_lpc_pc", int'(dut.pc_q), 'o1234);
    chk("prio_lpc_mem", int'(dut.mem['o1234]), 'o1111);
    load_ac('o55);
    sw[11:0] = 12'o3333;
    press(5'((1 << BD) | (1 << BR)));
    m['o1234] = 'o3333; mpc = 'o1235;
    chk("prio_dep_mem", int'(dut.mem['o1234]), 'o3333);
    chk("prio_dep_ac", int'(led[11:0]), 'o55);
    check_cpu("prio");

    // Panel ignored while running a JMP-to-self loop
    deposit('o400, 'o5200);
    load_pc('o400);
    sw[12] = 1'b1;
    repeat (10) @(negedge clk);
    chk("loop_running", int'(led[13]), 1);
    sw[11:0] = 12'o4321;
    press(5'(1 << BR));
    sw[12] = 1'b0;
    repeat (8) @(negedge clk);
    mpc = 'o400;
    check_cpu("loop");

    // Display: PC first, then AC after toggling select
    disp_check("disp_pc", mpc);
    load_ac('o1234);
    press(5'(1 << BC));
    disp_check("disp_ac", 'o1234);
    chk("dp", int'(dp), 1);

    // Random single-stepped instructions
    for (int t = 0; t < 40; t++) begin
      ok = 1'b0;
      p = 'o1000; op = 0; pg = 0; offs = 0; ind = 0; ea = 0; ptr = 'o1000; tgt = 'o1000;
      for (int g = 0; g < 100 && !ok; g++) begin
        p  = 'o1000 + int'($urandom % 'o6000);
        op = int'($urandom % 8);
        if ($urandom % 4 == 0) begin pg = 0; offs = 8 + int'($urandom % 8); end
        else begin pg = int'($urandom % 2); offs = int'($urandom % 128); end
        ind = int'($urandom % 2);
        ea  = (pg != 0 ? (p & 'o7600) : 0) + offs;
        ptr = 'o1000 + int'($urandom % 'o6000);
        tgt = (ind != 0 && ea >= 8 && ea <= 15) ? ptr + 1 : ptr;
        ok  = (ea != p) && (ind == 0 || (tgt != p && tgt != ea));
      end
      r = int'($urandom % 512);
      if (op < 6) ir = op * 512 + ind * 256 + pg * 128 + offs;
      else if (op == 6) ir = 'o6000 + r;
      else begin
        case ($urandom % 3)
          0: begin if ((r & 12) == 12) r = r - 4; ir = 'o7000 + (r & 255); end
          1: ir = 'o7400 + (r & 'o376);
          default: ir = 'o7401 + (r & 'o376);
        endcase
      end
      val = ($urandom % 4 == 0) ? 'o7777 : int'($urandom % 4096);
      if (op < 6) begin
        if (ind != 0) begin deposit(ea, ptr); deposit(tgt, val); end
        else deposit(ea, val);
      end
      deposit(p, ir);
      load_ac(int'($urandom % 4096));
      step_at(p);
      check_cpu("rnd");
      if (op < 6) begin
        chk("rnd_mem", int'(dut.mem[mea]), m[mea]);
        if (mptr >= 0) chk("rnd_aix", int'(dut.mem[mptr]), m[mptr]);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter REFRESH_BITS, default 17, sets the display refresh counter width; each digit is lit for 2^(REFRESH_BITS-2) clocks.
REQ-002 clk  in  1  system clock; every flop is rising-edge.
REQ-003 btnCpuReset  in  1  reset, asynchronous and active-low.
REQ-004 btnc  in  1  display-select button; toggles the shown register between PC and AC.
REQ-005 btnu  in  1  single-step button.
REQ-006 btnd  in  1  deposit button.
REQ-007 btnl  in  1  load-PC button.
REQ-008 btnr  in  1  load-AC button.
REQ-009 sw  in  13  sw[11:0] is the switch register; sw[12] is the RUN switch.
REQ-010 led  out  16  led[11:0]=AC, led[12]=L, led[13]=running, led[14]=halt latch, led[15]=0.
REQ-011 an  out  8  digit anodes, active-low.
REQ-012 seg  out  7  segments a..g, active-low.
REQ-013 dp  out  1  decimal point, active-low; constantly 1.

Function
REQ-014 Each button passes through a 2-flop synchronizer and a rising-edge detector, so one press is one action however long it is held.
REQ-015 Storage: 4096x12 memory with combinational read and synchronous write; 12-bit PC, AC, IR, MA; 1-bit link L.
REQ-016 CPU FSM states: IDLE, FETCH, DEFER, EXEC; one clock each.
REQ-017 IDLE -> FETCH when (sw[12]=1 and halt latch=0) or a step pulse occurs; otherwise IDLE.
REQ-018 FETCH: IR<=mem[PC]; PC<=PC+1 (mod 4096); MA<={IR[7] ? page of instruction address (bits 11:7) : 00000, IR[6:0]}; go to DEFER if IR[8]=1 and opcode<6, else EXEC.
REQ-019 DEFER: MA<=mem[MA]; if MA in 0010-0017 (octal), write mem[MA]+1 back and use the incremented value; go to EXEC.
REQ-020 EXEC, AND(0): AC<=AC&mem[MA].
REQ-021 EXEC, TAD(1): {L,AC}<=({L,AC}+mem[MA]); the carry out complements L.
REQ-022 EXEC, ISZ(2): mem[MA]<=mem[MA]+1; if the result is 0, PC<=PC+1.
REQ-023 EXEC, DCA(3): mem[MA]<=AC; AC<=0.
REQ-024 EXEC, JMS(4): mem[MA]<=PC; PC<=MA+1.
REQ-025 EXEC, JMP(5): PC<=MA.
REQ-026 EXEC, IOT(6): no operation.
REQ-027 OPR group 1 (IR[8]=0), in order: CLA(b7)/CLL(b6); then CMA(b5)/CML(b4); then IAC(b0); then RAR(b3)/RAL(b2) on {L,AC}, rotating twice when b1=1.
REQ-028 OPR group 2 (IR[8]=1, IR[0]=0): the skip condition is the OR of SMA(b6,AC[11]), SZA(b5,AC=0) and SNL(b4,L=1), inverted when b3=1; on skip PC<=PC+1.
REQ-029 OPR group 2 then applies CLA(b7), then OSR(b2, AC|=sw[11:0]), then HLT(b1, sets the halt latch).
REQ-030 OPR group 3 (IR[8]=1, IR[0]=1) is a no operation.
REQ-031 EXEC always returns to IDLE; a step in progress completes exactly one instruction.
REQ-032 Panel actions are honoured only in IDLE with the CPU not running (running = sw[12]=1 and halt latch=0); otherwise they are discarded.
REQ-033 Load-PC: PC<=sw[11:0] and the halt latch is cleared.
REQ-034 Load-AC: AC<=sw[11:0].
REQ-035 Deposit: mem[PC]<=sw[11:0]; PC<=PC+1.
REQ-036 A falling edge of sw[12] clears the halt latch.
REQ-037 If panel pulses coincide, only one is taken, in priority Load-PC > Deposit > Load-AC > Step.
REQ-038 Display: a free-running counter selects digit cnt[MSB:MSB-1], driving an[3:0] one-hot low; an[7:4]=1.
REQ-039 Digit i shows octal digit i of PC (select=0) or AC (select=1), with standard 0-7 patterns.

Reset
REQ-040 While btnCpuReset=0, asynchronously: PC, AC, IR, MA, L, halt latch and display select are 0; the FSM is in IDLE; the refresh counter is 0.
REQ-041 During reset the outputs are led=0, an=8'hFF, seg=7'h7F, dp=1.
REQ-042 Memory contents are not cleared by reset.
REQ-043 After release the first action starts on the next clock edge.

Verification
REQ-044 Reset, sw=0o200, press btnl, sw=0o7001, press btnd -> mem[0200]=7001 and PC=0201.
REQ-045 Load mem[0200..0202]={7200,1203,7402}, mem[0203]=0005, PC=0200, set sw[12]=1 -> AC=0005, halt latch=1, PC=0203, led[14]=1.
REQ-046 With AC=7777 and L=0, step TAD of 0001 -> AC=0000 and L=1.
REQ-047 ISZ on 7777 followed by JMP -> location becomes 0000 and the JMP is skipped (PC advances by 2).
REQ-048 JMS 0300 at address 0200 -> mem[0300]=0201 and PC=0301.
REQ-049 Press btnc with AC=1234 and REFRESH_BITS=4 -> digits 0..3 show 4,3,2,1 in turn and an[7:4] stays high.
